// File: rtl/pv_temp_sched.sv
// pv_temp_sched: clamps a bank of panel temperatures, streams them into the current
// pipeline one per clock and collects the returned currents in issue order.
module pv_temp_sched #(
    parameter int N_PANEL = 8,
    parameter int IDX_W = 3,
    parameter int SINGLE = 32,
    parameter int PIPE_LAT = 47,
    parameter logic [SINGLE-1:0] T_MIN = 32'h43888000,
    parameter logic [SINGLE-1:0] T_MAX = 32'h43C78000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              t_wr_en,
    input  logic [IDX_W-1:0]  t_wr_addr,
    input  logic [SINGLE-1:0] t_wr_data,
    output logic              ids_sta,
    output logic [SINGLE-1:0] ids_T,
    input  logic [SINGLE-1:0] ids_in,
    input  logic              ids_done,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [SINGLE-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              clamp_lo,
    output logic              clamp_hi
);
    localparam int CW = $clog2(N_PANEL + 1);
    localparam int WD_W = $clog2(PIPE_LAT + 8);
    localparam int WD_MAX = PIPE_LAT + 7;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t            state;
    logic [SINGLE-1:0] tbank [N_PANEL];
    logic [SINGLE-1:0] rbank [N_PANEL];
    logic [CW-1:0]     issue_idx, cap_cnt;
    logic [WD_W-1:0]   wd;
    logic [IDX_W-1:0]  sel;
    logic [SINGLE-1:0] raw, clamped;
    logic              lo, hi, cap_en, full_next;

    assign busy = state != IDLE;
    assign done = state == FIN;

    // Entry 0 is issued on the accepting edge itself, so IDLE looks at index 0.
    always_comb begin
        sel = state == IDLE ? '0 : issue_idx[IDX_W-1:0];
        raw = tbank[sel];
        lo = raw[SINGLE-1] || raw < T_MIN;
        hi = !raw[SINGLE-1] && raw > T_MAX;
        clamped = lo ? T_MIN : hi ? T_MAX : raw;
        cap_en = ids_done && (state == ISSUE || state == DRAIN) && cap_cnt != CW'(N_PANEL);
        full_next = cap_cnt == CW'(N_PANEL) || (cap_en && cap_cnt == CW'(N_PANEL - 1));
    end

    always_ff @(posedge clk) begin
        if (t_wr_en && state == IDLE) tbank[t_wr_addr] <= t_wr_data;
        if (cap_en) rbank[cap_cnt[IDX_W-1:0]] <= ids_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ids_sta <= 1'b0;
            ids_T <= '0;
            issue_idx <= '0;
            cap_cnt <= '0;
            wd <= '0;
            err <= 1'b0;
            clamp_lo <= 1'b0;
            clamp_hi <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_data <= rbank[rd_addr];
            if (cap_en) cap_cnt <= cap_cnt + CW'(1);
            case (state)
                IDLE: if (start) begin
                    state <= ISSUE;
                    ids_sta <= 1'b1;
                    ids_T <= clamped;
                    issue_idx <= CW'(1);
                    cap_cnt <= '0;
                    err <= 1'b0;
                    clamp_lo <= lo;
                    clamp_hi <= hi;
                end
                ISSUE: if (issue_idx == CW'(N_PANEL)) begin
                    ids_sta <= 1'b0;
                    wd <= '0;
                    state <= DRAIN;
                end else begin
                    ids_T <= clamped;
                    issue_idx <= issue_idx + CW'(1);
                    clamp_lo <= clamp_lo | lo;
                    clamp_hi <= clamp_hi | hi;
                end
                DRAIN: if (full_next) state <= FIN;
                    else if (wd == WD_W'(WD_MAX)) begin
                        err <= 1'b1;
                        state <= FIN;
                    end else wd <= wd + WD_W'(1);
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pv_temp_sched.md
Name: pv_temp_sched

Overview:
- Upstream sequencer for the PV drain-source current lookup/interpolation pipeline.
- Holds a bank of per-panel cell temperatures (IEEE-754 single) and clamps each one to the lookup table range.
- Issues one panel per clock into the current pipeline (sta/T), then collects the returned current words into a result bank in panel order.
- Signals completion of the sweep and raises a timeout error if results do not arrive.

Parameters:
- N_PANEL, 8, number of panels per sweep (power of two not required).
- IDX_W, 3, index width, ceil(log2(N_PANEL)).
- SINGLE, 32, float word width.
- PIPE_LAT, 47, fixed sta-to-done latency of the downstream current pipeline.
- T_MIN, 32'h43888000, lower clamp (273.0 K).
- T_MAX, 32'h43C78000, upper clamp (399.0 K).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle sweep request
- t_wr_en  in  1  temperature bank write strobe
- t_wr_addr  in  IDX_W  temperature bank write index
- t_wr_data  in  SINGLE  temperature (float, K)
- ids_sta  out  1  issue strobe to the current pipeline
- ids_T  out  SINGLE  clamped temperature to the current pipeline
- ids_in  in  SINGLE  current result from the pipeline
- ids_done  in  1  result-valid strobe from the pipeline
- rd_addr  in  IDX_W  result bank read index
- rd_data  out  SINGLE  result bank read data, 1-cycle latency
- busy  out  1  sweep in progress
- done  out  1  one-cycle sweep-complete pulse
- err  out  1  sticky timeout flag, cleared on accepted start
- clamp_lo  out  1  sticky: at least one temperature was raised to T_MIN during the sweep
- clamp_hi  out  1  sticky: at least one temperature was lowered to T_MAX during the sweep

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; all outputs are 0; issue and capture counters are 0.
  - Bank contents are undefined after reset.
  - Reset asserted mid-sweep aborts the sweep; no done pulse is produced.
- FSM states IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start=1 moves to ISSUE. On that same edge, clear err, clamp_lo, clamp_hi and both counters.
  - ISSUE: each cycle, ids_sta=1 and ids_T = clamp(tbank[issue_idx]), both registered. issue_idx increments. After N_PANEL issues, go to DRAIN.
  - DRAIN: wait until cap_cnt == N_PANEL, then go to FIN. A watchdog counts cycles spent in DRAIN; reaching PIPE_LAT+8 sets err=1 and goes to FIN.
  - FIN: done=1 for exactly one cycle, then return to IDLE.
- busy=1 in ISSUE, DRAIN and FIN.
- start while busy is ignored.
- t_wr_en while busy is ignored, so the bank stays stable for the sweep. Writes in IDLE take effect on the next edge.
- Clamp, as an integer compare on the raw bits:
  - Sign bit set, or bits < T_MIN → T_MIN, and set clamp_lo.
  - Sign clear and bits > T_MAX (this includes +Inf/NaN) → T_MAX, and set clamp_hi.
  - Otherwise the value passes through unchanged.
- Capture:
  - Every ids_done=1 while in ISSUE or DRAIN writes ids_in to rbank[cap_cnt] and increments cap_cnt. Results therefore land in issue order, because the pipeline latency is fixed.
  - ids_done in IDLE or FIN is ignored.
  - ids_done arriving after cap_cnt == N_PANEL is ignored.
- Result read:
  - rd_data is registered from rbank[rd_addr] and is valid at any time.
  - A read of an entry in the same cycle it is written returns the old value.
- Timing for N_PANEL=8, start sampled at edge 0:
  - ids_sta is high in cycles 1..8.
  - ids_done arrives in cycles 48..55.
  - done is high in cycle 56.
  - busy is high in cycles 1..56.
- Back-to-back: start in the cycle right after done is accepted (the FSM is in IDLE).

Test Plan:
- Bank written with 300.0 (0x43960000) at all 8 entries; start; pipeline model returns index-tagged currents → ids_sta high in cycles 1–8 with ids_T=0x43960000; done in cycle 56; rbank[i] reads back the tag for i; clamp flags and err stay 0.
- Entries 250.0 (0x437A0000), -5.0 (0xC0A00000), 450.0 (0x43E10000), NaN (0x7FC00000) → issued as 0x43888000, 0x43888000, 0x43C78000, 0x43C78000 respectively; clamp_lo=1 and clamp_hi=1.
- Pipeline model drops the last 2 ids_done → err=1 after PIPE_LAT+8 DRAIN cycles, done pulses once, entries 6–7 keep their stale values; the next start clears err.
- start held high throughout a sweep, plus t_wr_en pulses in cycle 10 → exactly one sweep runs and the bank is unchanged.
- rst driven low in cycle 30 → all outputs 0 immediately; no done pulse; a fresh start then completes normally.
- Stray ids_done in IDLE, and an extra ids_done after the 8th capture → cap_cnt is unaffected and rbank is unchanged.
